// File: rtl/wave_scheduler_if.sv
`timescale 1ns/1ps
// Control and status bundle between the game top level and the wave scheduler.
interface wave_scheduler_if;
  logic       game_en;
  logic       playing;
  logic       restart;
  logic       box_dropped;
  logic       collision;
  logic [9:0] obstacle_speed;
  logic [9:0] green_speed;
  logic       spawn_obstacle;
  logic       spawn_green;
  logic [3:0] wave_num;
  logic [1:0] phase;
  logic [7:0] countdown;

  modport master (
    output game_en, playing, restart, box_dropped, collision,
    input  obstacle_speed, green_speed, spawn_obstacle, spawn_green,
           wave_num, phase, countdown
  );

  modport slave (
    input  game_en, playing, restart, box_dropped, collision,
    output obstacle_speed, green_speed, spawn_obstacle, spawn_green,
           wave_num, phase, countdown
  );
endinterface

// File: rtl/wave_scheduler.sv
`timescale 1ns/1ps
// Wave progression: intro countdown, active spawning, deposit-driven wave
// completion, cooldown, and per-wave speed / spawn-interval scaling.
module wave_scheduler #(
  parameter int BASE_OBST_SPEED   = 5,
  parameter int BASE_GREEN_SPEED  = 6,
  parameter int SPEED_STEP        = 1,
  parameter int MAX_WAVE          = 15,
  parameter int INTRO_TICKS       = 120,
  parameter int COOLDOWN_TICKS    = 60,
  parameter int DEPOSITS_PER_WAVE = 3,
  parameter int SPAWN_BASE        = 90,
  parameter int SPAWN_STEP        = 5,
  parameter int SPAWN_MIN         = 30
) (
  input  logic            clk,
  input  logic            rst,
  wave_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    INTRO    = 2'b01,
    ACTIVE   = 2'b10,
    COOLDOWN = 2'b11
  } state_t;

  localparam int DEP_W = (DEPOSITS_PER_WAVE < 2) ? 1 : $clog2(DEPOSITS_PER_WAVE + 1);
  localparam logic [DEP_W-1:0] DEP_DONE     = DEP_W'(DEPOSITS_PER_WAVE);
  localparam logic [DEP_W-1:0] DEP_LAST     = DEP_W'(DEPOSITS_PER_WAVE - 1);
  localparam logic [7:0]       INTRO_LOAD   = 8'(INTRO_TICKS - 1);
  localparam logic [7:0]       COOL_LOAD    = 8'(COOLDOWN_TICKS - 1);
  localparam logic [3:0]       WAVE_CAP     = 4'(MAX_WAVE);
  localparam logic [31:0]      SPAWN_BASE_U = 32'(SPAWN_BASE);
  localparam logic [31:0]      SPAWN_MIN_U  = 32'(SPAWN_MIN);

  state_t           state_reg, state_next;
  logic [7:0]       countdown_reg, countdown_next;
  logic [3:0]       wave_reg, wave_next;
  logic [15:0]      spawn_cnt_reg, spawn_cnt_next;
  logic [DEP_W-1:0] deposit_reg, deposit_next;
  logic             green_turn_reg, green_turn_next;
  logic             collision_q_reg, collision_q_next;
  logic             spawn_obst_reg, spawn_obst_next;
  logic             spawn_green_reg, spawn_green_next;
  logic [9:0]       obst_speed_reg, obst_speed_next;
  logic [9:0]       green_speed_reg, green_speed_next;

  logic [31:0] spawn_cut;
  logic [15:0] interval_m1;
  logic        collision_rise;
  logic        wave_closing;

  // Interval floor is tested before subtracting so late waves never wrap.
  always_comb begin
    spawn_cut = 32'(wave_reg) * 32'(SPAWN_STEP);
    if (SPAWN_BASE_U <= SPAWN_MIN_U + spawn_cut) begin
      interval_m1 = 16'(SPAWN_MIN_U - 32'd1);
    end else begin
      interval_m1 = 16'(SPAWN_BASE_U - spawn_cut - 32'd1);
    end
  end

  assign collision_rise = bus.collision & ~collision_q_reg;
  assign wave_closing   = bus.box_dropped && (deposit_reg == DEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      countdown_reg   <= '0;
      wave_reg        <= '0;
      spawn_cnt_reg   <= '0;
      deposit_reg     <= '0;
      green_turn_reg  <= 1'b0;
      collision_q_reg <= 1'b0;
      spawn_obst_reg  <= 1'b0;
      spawn_green_reg <= 1'b0;
      obst_speed_reg  <= 10'(BASE_OBST_SPEED);
      green_speed_reg <= 10'(BASE_GREEN_SPEED);
    end else begin
      state_reg       <= state_next;
      countdown_reg   <= countdown_next;
      wave_reg        <= wave_next;
      spawn_cnt_reg   <= spawn_cnt_next;
      deposit_reg     <= deposit_next;
      green_turn_reg  <= green_turn_next;
      collision_q_reg <= collision_q_next;
      spawn_obst_reg  <= spawn_obst_next;
      spawn_green_reg <= spawn_green_next;
      obst_speed_reg  <= obst_speed_next;
      green_speed_reg <= green_speed_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    countdown_next   = countdown_reg;
    wave_next        = wave_reg;
    spawn_cnt_next   = spawn_cnt_reg;
    deposit_next     = deposit_reg;
    green_turn_next  = green_turn_reg;
    collision_q_next = collision_q_reg;
    spawn_obst_next  = 1'b0;
    spawn_green_next = 1'b0;
    // Speeds trail wave_num by one clock.
    obst_speed_next  = 10'(BASE_OBST_SPEED + int'(wave_reg) * SPEED_STEP);
    green_speed_next = 10'(BASE_GREEN_SPEED + int'(wave_reg) * SPEED_STEP);

    if (bus.restart) begin
      state_next       = IDLE;
      countdown_next   = '0;
      wave_next        = '0;
      spawn_cnt_next   = '0;
      deposit_next     = '0;
      green_turn_next  = 1'b0;
      collision_q_next = 1'b0;
    end else if (bus.playing) begin
      collision_q_next = bus.collision;
      case (state_reg)
        IDLE: begin
          if (bus.game_en) begin
            state_next     = INTRO;
            countdown_next = INTRO_LOAD;
          end
        end
        INTRO: begin
          if (bus.game_en) begin
            if (countdown_reg == 8'd0) begin
              state_next = ACTIVE;
            end else begin
              countdown_next = countdown_reg - 8'd1;
            end
          end
        end
        ACTIVE: begin
          if (deposit_reg == DEP_DONE) begin
            state_next      = COOLDOWN;
            countdown_next  = COOL_LOAD;
            deposit_next    = '0;
            spawn_cnt_next  = '0;
            green_turn_next = 1'b0;
            wave_next       = (wave_reg >= WAVE_CAP) ? WAVE_CAP : wave_reg + 4'd1;
          end else begin
            if (bus.box_dropped) begin
              deposit_next = deposit_reg + 1'b1;
            end
            // A fresh collision grants a full spawn interval of grace.
            if (collision_rise) begin
              spawn_cnt_next = '0;
            end else if (bus.game_en) begin
              if (spawn_cnt_reg == interval_m1) begin
                spawn_cnt_next = '0;
                if (!wave_closing) begin
                  spawn_obst_next  = 1'b1;
                  spawn_green_next = ~green_turn_reg;
                  green_turn_next  = ~green_turn_reg;
                end
              end else begin
                spawn_cnt_next = spawn_cnt_reg + 16'd1;
              end
            end
          end
        end
        COOLDOWN: begin
          if (bus.game_en) begin
            if (countdown_reg == 8'd0) begin
              state_next     = INTRO;
              countdown_next = INTRO_LOAD;
            end else begin
              countdown_next = countdown_reg - 8'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.phase          = state_reg;
    bus.countdown      = countdown_reg;
    bus.wave_num       = wave_reg;
    bus.spawn_obstacle = spawn_obst_reg;
    bus.spawn_green    = spawn_green_reg;
    bus.obstacle_speed = obst_speed_reg;
    bus.green_speed    = green_speed_reg;
  end

endmodule
